vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
VGA timing generator and output stage for the DE0 VGA controller, 640x480 at 60 Hz with a 25.175 MHz pixel clock.
- Produces the pixel coordinates xPos/yPos consumed by the pattern generators.
- Accepts the returned red/green/blue, blanks it outside the active area, and drives the DAC/connector pins with hsync/vsync aligned to the RGB.
- Sits between the pattern generator and the board VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, active level of hsync (0 = active-low)
VS_POL, 0, active level of vsync (0 = active-low)
PIPE_DLY, 1, pattern-generator latency in clocks from xPos/yPos to red/green/blue; legal range 0..4

Ports:
vga_clk  in  1  pixel clock
RST  in  1  asynchronous reset, active-high
xPos  out  10  current pixel column; 0 outside the active area
yPos  out  10  current pixel row; 0 outside the active area
red  in  10  pattern red, valid PIPE_DLY clocks after its xPos/yPos
green  in  10  pattern green, same timing as red
blue  in  10  pattern blue, same timing as red
vga_r  out  10  blanked red to DAC
vga_g  out  10  blanked green to DAC
vga_b  out  10  blanked blue to DAC
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
vga_blank_n  out  1  1 when the pixel on vga_r/g/b is visible
frame_start  out  1  one-clock pulse aligned with output pixel (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- hcnt counts 0..H_TOTAL-1 and wraps to 0.
- vcnt increments only when hcnt wraps, and wraps to 0 after V_TOTAL-1. A simultaneous wrap of hcnt and vcnt at (799,524) goes to (0,0) in one clock.
- Timing reference: cycle 0 is the first clock after RST deasserts. hcnt = n mod 800 during cycle n.
- Active region: hcnt < H_ACTIVE and vcnt < V_ACTIVE.
  - hsync region: H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync region: V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- xPos/yPos are registered. During cycle n+1 they carry the coordinates of counter state n, or 0 when that state is outside the active region.
- Alignment: red/green/blue for that pixel arrive during cycle n+1+PIPE_DLY. The outputs for that pixel (vga_r/g/b, vga_hs, vga_vs, vga_blank_n, frame_start) are registered and valid during cycle n+2+PIPE_DLY.
  - Sync, active and frame flags travel through a delay line of matching depth.
  - RGB is sampled on the edge that ends cycle n+1+PIPE_DLY.
- Blanking: vga_r/g/b equal the input colour when the delayed active flag is 1, else 0. vga_blank_n equals the delayed active flag.
- Sync levels: vga_hs = HS_POL inside the hsync region, else ~HS_POL. vga_vs follows the same rule with VS_POL.
- frame_start is 1 for exactly one clock per frame, for pixel (0,0).
- Reset values, all asynchronous:
  - hcnt=0, vcnt=0, xPos=0, yPos=0.
  - vga_r/g/b=0, vga_blank_n=0, frame_start=0.
  - vga_hs=~HS_POL, vga_vs=~VS_POL.
  - All delay-line stages cleared to the inactive/idle-sync state.
- Reset mid-frame: all of the above take effect immediately. After release, timing restarts from (0,0) with no partial pulses, and the stale delay-line contents must never appear on the pins.
- Widths: counters are 10 bits, sufficient for totals up to 1023. Parameter totals above 1023 are illegal and flagged by an elaboration-time check.

Decomposition:
- Package vga_timing_pkg:
  - 640x480@60 timing constants.
  - Derived H_TOTAL/V_TOTAL and sync start/end constants.
  - Width constant for the 10-bit coordinate/colour buses.
- Sub-module vga_delay_line: parameterised width/depth shift register with asynchronous active-high reset to a parameterised value. Used for the sync/active/frame flag pipeline.

Test Plan:
- Reset release, PIPE_DLY=1: vga_hs is low for exactly cycles 659..754; next low period starts at 1459; period 800 clocks.
- vga_vs: low for exactly 1600 clocks, starting at cycle 490*800+3 = 392003; repeats every 420000 clocks.
- Pattern model with 1-clock latency returning red=xPos[9:0]: vga_r during cycle n+3 equals pixel column for active pixels; vga_r=0 and vga_blank_n=0 for columns 640..799 and rows 480..524.
- PIPE_DLY=0 and 4 with a matching model latency: no colour/sync skew; the first visible pixel of row 0 appears at cycle 2+PIPE_DLY with vga_blank_n=1.
- Counter wrap: at hcnt=799, vcnt=524 the next state is (0,0); frame_start pulses once per 420000 clocks, aligned with the output of pixel (0,0).
- Assert RST at cycle 200000 for 5 clocks: all outputs take their reset values within the reset cycle; after release, vga_hs first goes low at cycle 659 relative to the release, and no sync pulse is truncated or duplicated.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and flag types for the DE0 VGA sync generator.
// Bus widths are fixed at 10 bits, so line and frame totals must stay at or below 1023.
package vga_timing_pkg;

   localparam int COORD_W     = 10;
   localparam int COUNT_LIMIT = (1 << COORD_W) - 1;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
   localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

   typedef logic [COORD_W-1:0] coord_t;

   // Per-pixel flags carried alongside the colour pipeline; all-zero is the idle state.
   typedef struct packed {
      logic active;
      logic hsync;
      logic vsync;
      logic frame;
   } vga_flags_t;

   localparam vga_flags_t FLAGS_IDLE = '0;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel bus between the sync generator, the pattern generator and the VGA pins.
// master = sync generator; slave = the pattern generator / pin side.
interface vga_sync_gen_if;
   import vga_timing_pkg::*;

   coord_t xPos;
   coord_t yPos;
   coord_t red;
   coord_t green;
   coord_t blue;
   coord_t vga_r;
   coord_t vga_g;
   coord_t vga_b;
   logic   vga_hs;
   logic   vga_vs;
   logic   vga_blank_n;
   logic   frame_start;

   modport master (
      output xPos, yPos, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start,
      input  red, green, blue
   );

   modport slave (
      input  xPos, yPos, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start,
      output red, green, blue
   );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with an asynchronous active-high reset to a chosen value.
module vga_delay_line #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             vga_clk,
   input  logic             RST,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge vga_clk or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator and blanking output stage: issues pixel coordinates, then
// realigns the returned colour with sync/blank flags delayed by the pattern latency.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int PIPE_DLY = 1
) (
   input  logic           vga_clk,
   input  logic           RST,
   vga_sync_gen_if.master vga
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

   if (H_TOTAL > COUNT_LIMIT || V_TOTAL > COUNT_LIMIT) begin : g_total_check
      $error("vga_sync_gen: line or frame total exceeds the 10-bit counter range");
   end

   if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_dly_check
      $error("vga_sync_gen: PIPE_DLY must lie in 0..4");
   end

   coord_t     hcnt;
   coord_t     vcnt;
   vga_flags_t flags_now;
   vga_flags_t flags_dly;

   always_ff @(posedge vga_clk or posedge RST) begin
      if (RST) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (hcnt == H_LAST) begin
         hcnt <= '0;
         vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
         hcnt <= hcnt + 1'b1;
      end
   end

   always_comb begin
      flags_now        = FLAGS_IDLE;
      flags_now.active = (hcnt < coord_t'(H_ACTIVE)) && (vcnt < coord_t'(V_ACTIVE));
      flags_now.hsync  = (hcnt >= coord_t'(HS_START)) && (hcnt < coord_t'(HS_END));
      flags_now.vsync  = (vcnt >= coord_t'(VS_START)) && (vcnt < coord_t'(VS_END));
      flags_now.frame  = (hcnt == '0) && (vcnt == '0);
   end

   always_ff @(posedge vga_clk or posedge RST) begin
      if (RST) begin
         vga.xPos <= '0;
         vga.yPos <= '0;
      end else begin
         vga.xPos <= flags_now.active ? hcnt : '0;
         vga.yPos <= flags_now.active ? vcnt : '0;
      end
   end

   // One stage covers the coordinate register, the rest match the pattern latency.
   vga_delay_line #(
      .WIDTH     ($bits(vga_flags_t)),
      .DEPTH     (PIPE_DLY + 1),
      .RESET_VAL (FLAGS_IDLE)
   ) u_flag_dly (
      .vga_clk (vga_clk),
      .RST     (RST),
      .din     (flags_now),
      .dout    (flags_dly)
   );

   always_ff @(posedge vga_clk or posedge RST) begin
      if (RST) begin
         vga.vga_r       <= '0;
         vga.vga_g       <= '0;
         vga.vga_b       <= '0;
         vga.vga_blank_n <= 1'b0;
         vga.frame_start <= 1'b0;
         vga.vga_hs      <= ~HS_POL;
         vga.vga_vs      <= ~VS_POL;
      end else begin
         vga.vga_r       <= flags_dly.active ? vga.red   : '0;
         vga.vga_g       <= flags_dly.active ? vga.green : '0;
         vga.vga_b       <= flags_dly.active ? vga.blue  : '0;
         vga.vga_blank_n <= flags_dly.active;
         vga.frame_start <= flags_dly.frame;
         vga.vga_hs      <= flags_dly.hsync ? HS_POL : ~HS_POL;
         vga.vga_vs      <= flags_dly.vsync ? VS_POL : ~VS_POL;
      end
   end

endmodule
